ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter THRESH, 26: minimum high-time in clk cycles that decodes as a 1 bit (50 MHz clk: 0-bit ~18 cycles, 1-bit ~35 cycles).
REQ-002 Parameter MIN_HIGH, 5: a high pulse shorter than this many cycles is a glitch.
REQ-003 Parameter RESET_CYCLES, 2500: low-time, or stuck-high time, that ends a frame (50 us at 50 MHz).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 din  input  1  asynchronous single-wire NZR LED data, GRB order, MSB first.
REQ-007 word  output  24  last complete decoded control word {G[7:0],R[7:0],B[7:0]}.
REQ-008 word_valid  output  1  one-cycle pulse when word updates.
REQ-009 frame_end  output  1  one-cycle pulse when a frame-end low period is detected.
REQ-010 bit_err  output  1  one-cycle pulse on glitch, stuck-high, or partial word at frame end.
REQ-011 pixel_count  output  8  words in current/last frame; present only with WS_RX_PIXCNT_EN.

Function
REQ-012 din SHALL pass through a 2-flop synchronizer plus one delay flop; rising and falling edges are detected on synchronized data only.
REQ-013 All outputs SHALL be registered; a din edge SHALL be reflected on outputs exactly 3 clk cycles after it is sampled.
REQ-014 States: IDLE, HIGH, LOW, STUCK; IDLE->HIGH on rising edge; HIGH->LOW on falling edge; LOW->HIGH on rising edge; LOW->IDLE when low count reaches RESET_CYCLES; HIGH->STUCK when high count reaches RESET_CYCLES; STUCK->IDLE on falling edge.
REQ-015 high_cnt SHALL clear on rising edge and count cycles in HIGH, saturating at RESET_CYCLES; low_cnt likewise in LOW.
REQ-016 On falling edge with high_cnt < MIN_HIGH: no bit is shifted, bit_err pulses, bit counter unchanged.
REQ-017 Otherwise the bit (high_cnt >= THRESH) SHALL shift into a 24-bit shift register from the LSB end, and the bit counter increments.
REQ-018 When the 24th bit is shifted: word takes the full 24 bits, word_valid pulses, bit counter returns to 0 in the same cycle.
REQ-019 word SHALL hold its value between word_valid pulses.
REQ-020 LOW->IDLE SHALL pulse frame_end; if bit counter != 0, bit_err pulses in the same cycle and the partial bits are discarded.
REQ-021 HIGH->STUCK SHALL pulse bit_err once and discard the partial word; no bits decode until return to IDLE.
REQ-022 A frame with zero bits, i.e. line held low from IDLE, SHALL produce no frame_end.
REQ-023 Period between bits is not checked; only the high time decides bit value.

Reset
REQ-024 reset SHALL force state IDLE, counters 0, shift register 0, synchronizer flops 0.
REQ-025 During and after reset, word=24'h000000, word_valid=0, frame_end=0, bit_err=0, pixel_count=0.
REQ-026 reset mid-word SHALL discard partial bits with no bit_err; decoding restarts on the next rising edge.

Configuration
REQ-027 Macro WS_RX_PIXCNT_EN defined: pixel_count port exists.
- Increments on each word_valid, saturating at 255.
- Holds through the frame_end pulse.
- The first word_valid after frame_end loads it to 1.
REQ-028 Macro WS_RX_PIXCNT_EN undefined: pixel_count port and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-029 Drive 24 bits 0x0F0F0F (0-bit 18 high/44 low, 1-bit 35/27) -> one word_valid, word=24'h0F0F0F, 3 cycles after the final falling edge.
REQ-030 Three words (FF0000, 00FF00, 0000FF) then 2500 cycles low -> three word_valid with those values, then one frame_end, no bit_err, pixel_count=3 (macro on).
REQ-031 10 bits then 2500 cycles low -> frame_end and bit_err in the same cycle, no word_valid; next frame of 24'hA5A5A5 decodes cleanly.
REQ-032 3-cycle high glitch inserted between bits 5 and 6 of 24'h123456 -> one bit_err, word=24'h123456.
REQ-033 din held high 2600 cycles mid-word -> single bit_err at high_cnt=2500, no word_valid; a following valid word decodes correctly.
REQ-034 reset asserted after 12 bits, released, full word 24'hC0FFEE sent -> all outputs 0 during reset, then word=24'hC0FFEE, no bit_err.

Source files
------------

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes GRB pixel words from an NZR line by measuring high time.
// Optional WS_RX_PIXCNT_EN macro adds a per-frame pixel counter output.
module ws2812_rx #(
    parameter int THRESH       = 26,
    parameter int MIN_HIGH     = 5,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] word,
    output logic        word_valid,
    output logic        frame_end,
    output logic        bit_err
`ifdef WS_RX_PIXCNT_EN
    ,
    output logic [7:0]  pixel_count
`endif
);

    localparam int CW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_dly;
    logic [CW-1:0] r_highCnt;
    logic [CW-1:0] r_lowCnt;
    logic [23:0] r_shift;
    logic [23:0] r_wordCap;
    logic [4:0]  r_bitCnt;
    logic        r_validP;
    logic        r_frameP;
    logic        r_errP;

    logic        w_rise;
    logic        w_fall;
    logic        w_bit;
    logic [23:0] w_shiftNext;

    assign w_rise      = r_sync2 & ~r_dly;
    assign w_fall      = ~r_sync2 & r_dly;
    assign w_bit       = (r_highCnt >= CW'(THRESH));
    assign w_shiftNext = {r_shift[22:0], w_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    // Decode FSM; its pulses land one stage ahead of the output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_highCnt <= '0;
            r_lowCnt  <= '0;
            r_shift   <= '0;
            r_wordCap <= '0;
            r_bitCnt  <= '0;
            r_validP  <= 1'b0;
            r_frameP  <= 1'b0;
            r_errP    <= 1'b0;
        end else begin
            r_validP <= 1'b0;
            r_frameP <= 1'b0;
            r_errP   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state   <= HIGH;
                        r_highCnt <= '0;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        r_state  <= LOW;
                        r_lowCnt <= '0;
                        if (r_highCnt < CW'(MIN_HIGH)) begin
                            r_errP <= 1'b1;
                        end else if (r_bitCnt == 5'd23) begin
                            r_wordCap <= w_shiftNext;
                            r_validP  <= 1'b1;
                            r_bitCnt  <= '0;
                            r_shift   <= '0;
                        end else begin
                            r_shift  <= w_shiftNext;
                            r_bitCnt <= r_bitCnt + 5'd1;
                        end
                    end else if (r_highCnt == CW'(RESET_CYCLES)) begin
                        r_state  <= STUCK;
                        r_errP   <= 1'b1;
                        r_bitCnt <= '0;
                        r_shift  <= '0;
                    end else begin
                        r_highCnt <= r_highCnt + CW'(1);
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_state   <= HIGH;
                        r_highCnt <= '0;
                    end else if (r_lowCnt == CW'(RESET_CYCLES)) begin
                        r_state  <= IDLE;
                        r_frameP <= 1'b1;
                        r_errP   <= (r_bitCnt != 5'd0);
                        r_bitCnt <= '0;
                        r_shift  <= '0;
                    end else begin
                        r_lowCnt <= r_lowCnt + CW'(1);
                    end
                end
                STUCK: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word       <= '0;
            word_valid <= 1'b0;
            frame_end  <= 1'b0;
            bit_err    <= 1'b0;
        end else begin
            word       <= r_wordCap;
            word_valid <= r_validP;
            frame_end  <= r_frameP;
            bit_err    <= r_errP;
        end
    end

`ifdef WS_RX_PIXCNT_EN
    logic r_newFrame;

    // The count survives frame_end so it can be read; the next word restarts it at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_count <= '0;
            r_newFrame  <= 1'b0;
        end else begin
            if (r_frameP) begin
                r_newFrame <= 1'b1;
            end
            if (r_validP) begin
                if (r_newFrame) begin
                    pixel_count <= 8'd1;
                    r_newFrame  <= 1'b0;
                end else if (pixel_count != 8'd255) begin
                    pixel_count <= pixel_count + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: vector table of short frames plus hand-written latency,
// multi-word, stuck-high and mid-word reset sequences.
module tb_ws2812_rx;

    logic        clk;
    logic        reset;
    logic        din;
    logic [23:0] word;
    logic        wordValid;
    logic        frameEnd;
    logic        bitErr;
`ifdef WS_RX_PIXCNT_EN
    logic [7:0]  pixelCount;
`endif

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .word       (word),
        .word_valid (wordValid),
        .frame_end  (frameEnd),
        .bit_err    (bitErr)
`ifdef WS_RX_PIXCNT_EN
        ,
        .pixel_count(pixelCount)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int testsRun   = 0;
    int testsFailed = 0;

    int cntValid = 0;
    int cntErr   = 0;
    int cntFrame = 0;
    logic [23:0] wordLog [64];
    logic [23:0] lastWord = '0;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (wordValid) begin
            wordLog[cntValid % 64] = word;
            lastWord = word;
            cntValid = cntValid + 1;
        end
        if (bitErr) cntErr = cntErr + 1;
        if (frameEnd) cntFrame = cntFrame + 1;
    end

    typedef struct {
        logic [23:0] data;
        int          nbits;
        int          glitchAfter;
        int          lowTail;
        logic [23:0] expWord;
        int          expValid;
        int          expErr;
        int          expFrame;
    } vec_t;

    vec_t vecs [4];
    int vB, eB, fB;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (act !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic holdLevel(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        holdLevel(1'b1, b ? 35 : 18);
        holdLevel(1'b0, b ? 27 : 44);
    endtask

    task automatic applyStimulus(input logic [23:0] data, input int nbits, input int glitchAfter);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitchAfter) begin
                holdLevel(1'b1, 3);
                holdLevel(1'b0, 20);
            end
            sendBit(data[23-i]);
        end
    endtask

    task automatic snap();
        vB = cntValid;
        eB = cntErr;
        fB = cntFrame;
    endtask

    initial begin
        vecs[0] = '{24'h000000, 0,  -1, 3000, 24'h0F0F0F, 0, 0, 0};
        vecs[1] = '{24'hFFC000, 10, -1, 2600, 24'h0F0F0F, 0, 1, 1};
        vecs[2] = '{24'hA5A5A5, 24, -1, 2600, 24'hA5A5A5, 1, 0, 1};
        vecs[3] = '{24'h123456, 24, 5,  2600, 24'h123456, 1, 1, 1};

        din   = 1'b0;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset word", 32'(word), 32'h0);
        checkOutput("reset word_valid", 32'(wordValid), 32'h0);
        checkOutput("reset frame_end", 32'(frameEnd), 32'h0);
        checkOutput("reset bit_err", 32'(bitErr), 32'h0);
        reset = 1'b0;
        holdLevel(1'b0, 5);

        // Latency: word_valid must appear on the 4th rising edge after the last falling edge.
        snap();
        applyStimulus(24'h0F0F0F, 23, -1);
        holdLevel(1'b1, 35);
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("latency early valid", 32'(wordValid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("latency valid", 32'(wordValid), 32'h1);
        checkOutput("latency word", 32'(word), 32'h0F0F0F);
        holdLevel(1'b0, 2600);
        checkOutput("latency frame_end count", 32'(cntFrame - fB), 32'd1);
        checkOutput("latency bit_err count", 32'(cntErr - eB), 32'd0);

        for (int v = 0; v < 4; v++) begin
            snap();
            applyStimulus(vecs[v].data, vecs[v].nbits, vecs[v].glitchAfter);
            holdLevel(1'b0, vecs[v].lowTail);
            checkOutput($sformatf("vec%0d word", v), 32'(word), 32'(vecs[v].expWord));
            checkOutput($sformatf("vec%0d valid count", v), 32'(cntValid - vB), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d err count", v), 32'(cntErr - eB), 32'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d frame count", v), 32'(cntFrame - fB), 32'(vecs[v].expFrame));
        end

        snap();
        applyStimulus(24'hFF0000, 24, -1);
        applyStimulus(24'h00FF00, 24, -1);
        applyStimulus(24'h0000FF, 24, -1);
        holdLevel(1'b0, 2600);
        checkOutput("3word valid count", 32'(cntValid - vB), 32'd3);
        checkOutput("3word first", 32'(wordLog[vB % 64]), 32'hFF0000);
        checkOutput("3word second", 32'(wordLog[(vB + 1) % 64]), 32'h00FF00);
        checkOutput("3word third", 32'(wordLog[(vB + 2) % 64]), 32'h0000FF);
        checkOutput("3word frame count", 32'(cntFrame - fB), 32'd1);
        checkOutput("3word err count", 32'(cntErr - eB), 32'd0);
`ifdef WS_RX_PIXCNT_EN
        checkOutput("3word pixel_count", 32'(pixelCount), 32'd3);
`endif

        snap();
        applyStimulus(24'hFF00FF, 8, -1);
        holdLevel(1'b1, 2600);
        holdLevel(1'b0, 100);
        checkOutput("stuck err count", 32'(cntErr - eB), 32'd1);
        checkOutput("stuck valid count", 32'(cntValid - vB), 32'd0);
        checkOutput("stuck frame count", 32'(cntFrame - fB), 32'd0);
        snap();
        applyStimulus(24'h5A5A5A, 24, -1);
        holdLevel(1'b0, 2600);
        checkOutput("after stuck word", 32'(word), 32'h5A5A5A);
        checkOutput("after stuck valid count", 32'(cntValid - vB), 32'd1);
        checkOutput("after stuck err count", 32'(cntErr - eB), 32'd0);
`ifdef WS_RX_PIXCNT_EN
        checkOutput("after stuck pixel_count", 32'(pixelCount), 32'd1);
`endif

        applyStimulus(24'hC0FFEE, 12, -1);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midreset word", 32'(word), 32'h0);
        checkOutput("midreset word_valid", 32'(wordValid), 32'h0);
        checkOutput("midreset frame_end", 32'(frameEnd), 32'h0);
        checkOutput("midreset bit_err", 32'(bitErr), 32'h0);
`ifdef WS_RX_PIXCNT_EN
        checkOutput("midreset pixel_count", 32'(pixelCount), 32'h0);
`endif
        reset = 1'b0;
        holdLevel(1'b0, 5);
        snap();
        applyStimulus(24'hC0FFEE, 24, -1);
        holdLevel(1'b0, 2600);
        checkOutput("postreset word", 32'(word), 32'hC0FFEE);
        checkOutput("postreset valid count", 32'(cntValid - vB), 32'd1);
        checkOutput("postreset err count", 32'(cntErr - eB), 32'd0);
        checkOutput("postreset last logged", 32'(lastWord), 32'hC0FFEE);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
